lobo_video_timing: RTL and testbench
====================================

# lobo_video_timing

Parametrised raster timing generator for the LoboVIC HDMI video path. It replaces hard-wired 640x480 counters with a configurable sync/blank engine. It supports any VESA/CEA-style mode and optional VIC-style pixel replication. It drives the pixel pipeline and TMDS encoders with sync, data-enable, coordinates, frame/line strobes and an optional raster-compare interrupt toward the CPU/register side.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync and back porch in lines
- H_POL / V_POL, 0 / 0, sync active level (0 = active-low)
- SCALE, 1, pixel/line replication factor, 1..8
- CW, 12, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk_pixel  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  advance one pixel position when high; all outputs hold when low
- hsync  out  1  horizontal sync at H_POL level
- vsync  out  1  vertical sync at V_POL level
- de  out  1  high in the active area
- x / y  out  CW  raw position; valid when de=1
- vx / vy  out  CW  scaled position, x/SCALE and y/SCALE
- pix_stb  out  1  high when de=1 and x%SCALE==0 (new source pixel)
- line_start  out  1  one-cycle pulse at x=0
- frame_start  out  1  one-cycle pulse at x=0, y=0
- raster_line  in  CW  compare line (raster IRQ)
- irq_ack  in  1  clears raster_irq
- raster_irq  out  1  level interrupt

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Position order per axis: active, front porch, sync, back porch.
- Internal counters h, v. Each en=1 edge: h increments; at H_TOTAL-1, h wraps to 0 and v increments; v wraps to 0 after V_TOTAL-1.
- All outputs are registered and decoded from the new (h,v). Every output is therefore aligned to the position it reports.
- hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on v and is line-aligned: it changes only with h wrap.
- de = (h < H_ACTIVE) && (v < V_ACTIVE).
- vx/vy come from replication sub-counters, not dividers. vx resets to 0 at h=0. vy resets to 0 at v=0 and increments every SCALE lines.
- With SCALE=1: vx=x, vy=y, pix_stb=de.
- Raster IRQ: set on the line_start cycle when y == raster_line. Held until an irq_ack cycle.
- If set and irq_ack coincide, set wins.
- raster_line >= V_TOTAL never fires.

## Timing
- Reset values: h=H_TOTAL-1, v=V_TOTAL-1 internally. Outputs: hsync=!H_POL, vsync=!V_POL, de=0, x=y=vx=vy=0, pix_stb=0, line_start=0, frame_start=0, raster_irq=0.
- First en=1 edge after reset: x=0, y=0, de=1, frame_start=1, line_start=1. Latency is 1 cycle from en to position change.
- en low: every output holds its value, including pulses. Downstream qualifies strobes with en.
- Reset asserted mid-frame: immediate return to reset values. Any pending IRQ is lost.
- Line period is H_TOTAL en-cycles; frame period is H_TOTAL*V_TOTAL en-cycles.

## Configuration
- LOBO_VT_RASTER_IRQ_EN defined: raster compare logic as above.
- Undefined: raster_irq is constant 0; raster_line and irq_ack are ignored. Ports remain for a stable interface.

## Structure
- Package lobo_video_pkg holds:
  - mode constant sets (640x480@60, 800x600@60, 1280x720@60), with porch/sync/polarity values
  - the CW default
  - a position typedef {x, y, de, hsync, vsync}
- Sub-module lobo_vt_axis: one counter-plus-decode per axis, parametrised by ACTIVE/FP/SYNC/BP/POL. It is instantiated twice; the vertical instance is stepped by the horizontal wrap.

## Test plan
Small mode for all tests: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), POL=0, SCALE=2.
- Reset then en=1 continuously -> first edge x=0,y=0,de=1,frame_start=1. hsync low at x=10..12. frame_start repeats every 128 cycles.
- Count de cycles over one frame -> exactly 32. vsync low on lines 5..6 only, changing at x=0.
- SCALE=2 -> vx sequence 0,0,1,1,2,2,3,3 per line. pix_stb at x=0,2,4,6. vy=1 on lines 2 and 3.
- en toggled 1-0-0-1 -> outputs frozen during the low cycles. Position advances by exactly 2 over four cycles.
- raster_line=3 with LOBO_VT_RASTER_IRQ_EN -> raster_irq rises at the y=3 line_start. irq_ack on the same cycle leaves it set. A later irq_ack clears it. Without the macro, raster_irq stays 0.
- rst_n pulsed low at y=2,x=5 -> outputs take reset values asynchronously. First en edge after release gives frame_start=1.

Source files
------------

// File: rtl/lobo_video_pkg.sv
// Shared definitions for the LoboVIC raster timing generator: standard
// mode constants, the default coordinate width and a position record.
package lobo_video_pkg;

  // Default coordinate/counter width; holds totals up to 4095.
  localparam int CW_DEFAULT = 12;

  // One complete video mode: porches, sync widths and sync polarity.
  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        h_pol;
    logic        v_pol;
  } mode_t;

  localparam mode_t MODE_640X480_60 = '{
    h_active: 16'd640,  h_fp: 16'd16,  h_sync: 16'd96,  h_bp: 16'd48,
    v_active: 16'd480,  v_fp: 16'd10,  v_sync: 16'd2,   v_bp: 16'd33,
    h_pol: 1'b0, v_pol: 1'b0
  };

  localparam mode_t MODE_800X600_60 = '{
    h_active: 16'd800,  h_fp: 16'd40,  h_sync: 16'd128, h_bp: 16'd88,
    v_active: 16'd600,  v_fp: 16'd1,   v_sync: 16'd4,   v_bp: 16'd23,
    h_pol: 1'b1, v_pol: 1'b1
  };

  localparam mode_t MODE_1280X720_60 = '{
    h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40,  h_bp: 16'd220,
    v_active: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,   v_bp: 16'd20,
    h_pol: 1'b1, v_pol: 1'b1
  };

  // Position as seen by the pixel pipeline.
  typedef struct packed {
    logic [CW_DEFAULT-1:0] x;
    logic [CW_DEFAULT-1:0] y;
    logic                  de;
    logic                  hsync;
    logic                  vsync;
  } pos_t;

  // Total positions on one axis (active + front porch + sync + back porch).
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/lobo_vt_axis.sv
// One raster axis: a wrapping position counter plus registered decode of
// position and sync. The counter only moves on step_i; the next-state
// values are exported so the top can register its own decodes aligned
// with this axis.
module lobo_vt_axis
  import lobo_video_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int CW     = CW_DEFAULT
) (
  input  logic          clk_pixel,
  input  logic          rst_n,
  input  logic          step_i,
  output logic          wrap_o,      // counter sits on its last position
  output logic [CW-1:0] cnt_d_o,     // counter value after this cycle
  output logic          active_d_o,  // cnt_d_o lies in the active region
  output logic [CW-1:0] pos_o,       // registered position, 0 out of reset
  output logic          sync_o       // registered sync at POL level
);

  localparam int            TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pos_q;
  logic          sync_q, sync_d;
  logic          active_d;

  assign wrap_o = (cnt_q == LAST);

  // Next counter value: wrap to 0 after the last position.
  always_comb begin
    cnt_d = cnt_q;
    if (step_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Decode of the upcoming position so registered outputs line up with it.
  always_comb begin
    active_d = (cnt_d < ACT_END);
    sync_d   = ((cnt_d >= SYNC_START) && (cnt_d < SYNC_END)) ? POL : !POL;
  end

  // Counter and decoded outputs; reset parks the counter on its last
  // position so the first step lands on 0.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= LAST;
      pos_q  <= '0;
      sync_q <= !POL;
    end else if (step_i) begin
      cnt_q  <= cnt_d;
      pos_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_d_o    = cnt_d;
  assign active_d_o = active_d;
  assign pos_o      = pos_q;
  assign sync_o     = sync_q;

endmodule

// File: rtl/lobo_video_timing.sv
// Configurable raster timing generator for the LoboVIC HDMI path.
// Produces sync, data enable, raw and replicated coordinates, line/frame
// strobes and an optional raster-compare interrupt.
// Build option: define LOBO_VT_RASTER_IRQ_EN to enable the raster IRQ;
// otherwise raster_irq is tied low and raster_line/irq_ack are ignored.
module lobo_video_timing
  import lobo_video_pkg::*;
#(
  parameter int H_ACTIVE = int'(MODE_640X480_60.h_active),
  parameter int H_FP     = int'(MODE_640X480_60.h_fp),
  parameter int H_SYNC   = int'(MODE_640X480_60.h_sync),
  parameter int H_BP     = int'(MODE_640X480_60.h_bp),
  parameter int V_ACTIVE = int'(MODE_640X480_60.v_active),
  parameter int V_FP     = int'(MODE_640X480_60.v_fp),
  parameter int V_SYNC   = int'(MODE_640X480_60.v_sync),
  parameter int V_BP     = int'(MODE_640X480_60.v_bp),
  parameter bit H_POL    = MODE_640X480_60.h_pol,
  parameter bit V_POL    = MODE_640X480_60.v_pol,
  parameter int SCALE    = 1,
  parameter int CW       = CW_DEFAULT
) (
  input  logic          clk_pixel,
  input  logic          rst_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [CW-1:0] vx,
  output logic [CW-1:0] vy,
  output logic          pix_stb,
  output logic          line_start,
  output logic          frame_start,
  input  logic [CW-1:0] raster_line,
  input  logic          irq_ack,
  output logic          raster_irq
);

  // Replication sub-counters run 0..SCALE-1 (SCALE is at most 8).
  localparam logic [2:0] REP_LAST = 3'(SCALE - 1);

  logic          h_wrap, h_active_d, v_active_d, v_wrap_unused;
  logic [CW-1:0] h_next, v_next;

  lobo_vt_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(H_POL), .CW(CW)
  ) u_h_axis (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .step_i    (en),
    .wrap_o    (h_wrap),
    .cnt_d_o   (h_next),
    .active_d_o(h_active_d),
    .pos_o     (x),
    .sync_o    (hsync)
  );

  // Vertical axis advances only when the line wraps, so vsync and y
  // change exactly at x=0.
  lobo_vt_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(V_POL), .CW(CW)
  ) u_v_axis (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .step_i    (en && h_wrap),
    .wrap_o    (v_wrap_unused),
    .cnt_d_o   (v_next),
    .active_d_o(v_active_d),
    .pos_o     (y),
    .sync_o    (vsync)
  );

  logic          de_q, de_d;
  logic          pix_stb_q, pix_stb_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [2:0]    hrep_q, hrep_d, vrep_q, vrep_d;
  logic [CW-1:0] vx_q, vx_d, vy_q, vy_d;

  // Horizontal replication: vx steps every SCALE pixels, restarting at x=0.
  always_comb begin
    hrep_d = hrep_q;
    vx_d   = vx_q;
    if (h_next == '0) begin
      hrep_d = '0;
      vx_d   = '0;
    end else if (hrep_q == REP_LAST) begin
      hrep_d = '0;
      vx_d   = vx_q + CW'(1);
    end else begin
      hrep_d = hrep_q + 3'd1;
    end
  end

  // Vertical replication: vy steps every SCALE lines, restarting at y=0.
  always_comb begin
    vrep_d = vrep_q;
    vy_d   = vy_q;
    if (h_wrap) begin
      if (v_next == '0) begin
        vrep_d = '0;
        vy_d   = '0;
      end else if (vrep_q == REP_LAST) begin
        vrep_d = '0;
        vy_d   = vy_q + CW'(1);
      end else begin
        vrep_d = vrep_q + 3'd1;
      end
    end
  end

  // Strobes and data enable decoded from the upcoming position.
  always_comb begin
    de_d          = h_active_d && v_active_d;
    pix_stb_d     = de_d && (hrep_d == '0);
    line_start_d  = (h_next == '0);
    frame_start_d = line_start_d && (v_next == '0);
  end

  // Output and sub-counter registers; everything holds while en is low.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      de_q          <= 1'b0;
      pix_stb_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hrep_q        <= '0;
      vrep_q        <= '0;
      vx_q          <= '0;
      vy_q          <= '0;
    end else if (en) begin
      de_q          <= de_d;
      pix_stb_q     <= pix_stb_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hrep_q        <= hrep_d;
      vrep_q        <= vrep_d;
      vx_q          <= vx_d;
      vy_q          <= vy_d;
    end
  end

  assign de          = de_q;
  assign pix_stb     = pix_stb_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign vx          = vx_q;
  assign vy          = vy_q;

`ifdef LOBO_VT_RASTER_IRQ_EN
  logic irq_q;
  logic irq_set;

  // Lines beyond V_TOTAL-1 never match because v_next never reaches them.
  assign irq_set = en && line_start_d && (v_next == raster_line);

  // Level interrupt; a new match beats a simultaneous acknowledge.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else if (irq_set) begin
      irq_q <= 1'b1;
    end else if (irq_ack) begin
      irq_q <= 1'b0;
    end
  end

  assign raster_irq = irq_q;
`else
  logic irq_inputs_unused;
  assign irq_inputs_unused = ^{raster_line, irq_ack};
  assign raster_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_lobo_video_timing.sv
// Directed bench for lobo_video_timing in a small 16x8 mode with SCALE=2.
// Expected outputs come from an arithmetic position model pushed to a
// scoreboard on each drive and popped after the following clock edge.
module tb_lobo_video_timing;

  localparam int HT = 16;
  localparam int VT = 8;
`ifdef LOBO_VT_RASTER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk_pixel = 1'b0;
  logic        rst_n;
  logic        en;
  logic        irq_ack;
  logic [11:0] raster_line;
  logic        hsync, vsync, de, pix_stb, line_start, frame_start, raster_irq;
  logic [11:0] x, y, vx, vy;

  always #5 clk_pixel = ~clk_pixel;

  lobo_video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .SCALE(2), .CW(12)
  ) dut (
    .clk_pixel  (clk_pixel),
    .rst_n      (rst_n),
    .en         (en),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .x          (x),
    .y          (y),
    .vx         (vx),
    .vy         (vy),
    .pix_stb    (pix_stb),
    .line_start (line_start),
    .frame_start(frame_start),
    .raster_line(raster_line),
    .irq_ack    (irq_ack),
    .raster_irq (raster_irq)
  );

  typedef struct {
    logic [11:0] x, y, vx, vy;
    logic        de, hs, vs, ps, ls, fs, irq;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state
  int mh = HT - 1;
  int mv = VT - 1;
  bit started = 1'b0;
  bit m_irq = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    if (!started) begin
      e.x = '0; e.y = '0; e.vx = '0; e.vy = '0;
      e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
      e.ps = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
    end else begin
      e.x  = 12'(mh);
      e.y  = 12'(mv);
      e.vx = 12'(mh / 2);
      e.vy = 12'(mv / 2);
      e.de = (mh < 8) && (mv < 4);
      e.hs = !((mh >= 10) && (mh < 13));
      e.vs = !((mv >= 5) && (mv < 7));
      e.ps = e.de && (mh % 2 == 0);
      e.ls = (mh == 0);
      e.fs = (mh == 0) && (mv == 0);
    end
    e.irq = IRQ_ON ? m_irq : 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    mh = HT - 1;
    mv = VT - 1;
    started = 1'b0;
    m_irq = 1'b0;
  endtask

  task automatic compare_pop();
    exp_t e;
    e = sb_q.pop_front();
    chk("x",           32'(x),           32'(e.x));
    chk("y",           32'(y),           32'(e.y));
    chk("vx",          32'(vx),          32'(e.vx));
    chk("vy",          32'(vy),          32'(e.vy));
    chk("de",          32'(de),          32'(e.de));
    chk("hsync",       32'(hsync),       32'(e.hs));
    chk("vsync",       32'(vsync),       32'(e.vs));
    chk("pix_stb",     32'(pix_stb),     32'(e.ps));
    chk("line_start",  32'(line_start),  32'(e.ls));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
    chk("raster_irq",  32'(raster_irq),  32'(e.irq));
    $display("cyc=%0d en=%0b ack=%0b x=%0d y=%0d vx=%0d vy=%0d de=%0b hs=%0b vs=%0b ps=%0b ls=%0b fs=%0b irq=%0b",
             cyc, en, irq_ack, x, y, vx, vy, de, hsync, vsync, pix_stb, line_start, frame_start, raster_irq);
  endtask

  // Drive one cycle, advance the model, then check after the clock edge.
  task automatic step(input logic en_v, input logic ack_v);
    en = en_v;
    irq_ack = ack_v;
    if (rst_n) begin
      if (en_v) begin
        started = 1'b1;
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
      if (en_v && mh == 0 && mv == int'(raster_line)) m_irq = 1'b1;
      else if (ack_v) m_irq = 1'b0;
    end
    sb_q.push_back(model_out());
    @(posedge clk_pixel);
    #1;
    cyc++;
    compare_pop();
  endtask

  initial begin
    int de_count;
    int fs_count;
    int fs_first;
    int fs_last;
    int x_before;

    rst_n = 1'b0;
    en = 1'b0;
    irq_ack = 1'b0;
    raster_line = 12'd3;

    // Reset state, including en ignored while reset is held
    repeat (2) @(posedge clk_pixel);
    #1;
    sb_q.push_back(model_out());
    compare_pop();
    step(1'b1, 1'b0);
    rst_n = 1'b1;

    // First frame plus the first edge of the next: de count and frame period
    de_count = 0; fs_count = 0; fs_first = -1; fs_last = -1;
    for (int i = 0; i < 129; i++) begin
      step(1'b1, 1'b0);
      if (i < 128 && de === 1'b1) de_count++;
      if (frame_start === 1'b1) begin
        fs_count++;
        if (fs_first < 0) fs_first = i;
        fs_last = i;
      end
    end
    chk("de_per_frame", 32'(de_count), 32'd32);
    chk("fs_count", 32'(fs_count), 32'd2);
    chk("fs_first", 32'(fs_first), 32'd0);
    chk("fs_period", 32'(fs_last - fs_first), 32'd128);

    // Acknowledge clears the IRQ raised during the first frame
    step(1'b1, 1'b1);
    chk("irq_ack_clear", 32'(raster_irq), 32'd0);

    // Acknowledge coinciding with the y=3 line start: set wins
    while (!(mh == HT - 1 && mv == 2)) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("irq_set_wins", 32'(raster_irq), 32'(IRQ_ON));
    chk("irq_line_y", 32'(y), 32'd3);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("irq_later_ack", 32'(raster_irq), 32'd0);

    // en pattern 1-0-0-1 advances by exactly two positions
    x_before = mh;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("en_gap_advance", 32'(x), 32'(x_before + 2));

    // Pending IRQ at y=2,x=5, then asynchronous reset mid-frame
    raster_line = 12'd1;
    while (!(mh == 4 && mv == 2)) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("irq_pending", 32'(raster_irq), 32'(IRQ_ON));
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    sb_q.push_back(model_out());
    compare_pop();
    chk("irq_lost_on_reset", 32'(raster_irq), 32'd0);
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    raster_line = 12'd9;
    step(1'b1, 1'b0);
    chk("fs_after_reset", 32'(frame_start), 32'd1);

    // A compare line beyond V_TOTAL never raises the IRQ
    for (int i = 0; i < 130; i++) step(1'b1, 1'b0);
    chk("irq_out_of_range", 32'(raster_irq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
